proc_fsm_param: RTL and testbench

Parametrised multi-cycle processor block: a generalised control FSM together with its datapath. It includes an NREGS × DATA_W register file, an A operand register, a G result register and a shared bus. It accepts one instruction per `w` handshake, executes LOAD/MOVE in one cycle and ALU ops in three, and pulses `done` on completion. It is the successor of the fixed 4-register, 2-bit-opcode controller, and it integrates the datapath that the controller previously only steered.

---
 rtl/proc_fsm_param_if.sv | 32 +++
 rtl/proc_fsm_param.sv | 141 ++++++++++++++
 tb/tb_proc_fsm_param.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/proc_fsm_param_if.sv
// Instruction/status bundle for proc_fsm_param; master drives instructions and
// the debug read index, slave returns status, bus value and debug read data.
interface proc_fsm_param_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4
);
  localparam int unsigned IDX_W = $clog2(NREGS);

  logic              w;
  logic [2:0]        op;
  logic [IDX_W-1:0]  rx;
  logic [IDX_W-1:0]  ry;
  logic [DATA_W-1:0] din;
  logic              busy;
  logic              done;
  logic              err;
  logic              carry;
  logic              zero;
  logic [DATA_W-1:0] bus;
  logic [IDX_W-1:0]  dbg_sel;
  logic [DATA_W-1:0] dbg_data;

  modport master (
    output w, op, rx, ry, din, dbg_sel,
    input  busy, done, err, carry, zero, bus, dbg_data
  );

  modport slave (
    input  w, op, rx, ry, din, dbg_sel,
    output busy, done, err, carry, zero, bus, dbg_data
  );
endinterface

// File: rtl/proc_fsm_param.sv
// Multi-cycle processor: control FSM, NREGS x DATA_W register file, A/G registers, shared bus.
// Define PROC_XOR_EN to make op 101 execute XOR; otherwise it is treated as illegal.
module proc_fsm_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREGS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  proc_fsm_param_if.slave  p
);
  localparam int unsigned IDX_W = $clog2(NREGS);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_MOVE, S_ALU_A, S_ALU_G, S_ALU_WB, S_ERR
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [2:0]        r_op_q;
  logic [IDX_W-1:0]  r_rx_q;
  logic [IDX_W-1:0]  r_ry_q;
  logic [DATA_W-1:0] r_din_q;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_g;
  logic              r_carry_nxt;
  logic              r_carry;
  logic              r_zero;
  logic [DATA_W-1:0] r_regs [NREGS];

  logic              w_op_ok;
  logic              w_idx_ok;
  logic [DATA_W-1:0] w_bus;
  logic [DATA_W:0]   w_alu;

  // Legality is judged on the live inputs, so an illegal instruction goes straight to ERR.
  always_comb begin
    w_op_ok = 1'b0;
    case (p.op)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b100: w_op_ok = 1'b1;
`ifdef PROC_XOR_EN
      3'b101: w_op_ok = 1'b1;
`endif
      default: w_op_ok = 1'b0;
    endcase
    w_idx_ok = (32'(p.rx) < NREGS) && (32'(p.ry) < NREGS);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (p.w) begin
          if (!(w_op_ok && w_idx_ok)) w_next = S_ERR;
          else if (p.op == 3'b000)    w_next = S_LOAD;
          else if (p.op == 3'b001)    w_next = S_MOVE;
          else                        w_next = S_ALU_A;
        end
      end
      S_ALU_A: w_next = S_ALU_G;
      S_ALU_G: w_next = S_ALU_WB;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_bus = '0;
    case (r_state)
      S_LOAD:   w_bus = r_din_q;
      S_MOVE:   w_bus = r_regs[r_ry_q];
      S_ALU_A:  w_bus = r_regs[r_rx_q];
      S_ALU_G:  w_bus = r_regs[r_ry_q];
      S_ALU_WB: w_bus = r_g;
      default:  w_bus = '0;
    endcase
  end

  // One extra bit holds ADD carry-out or SUB borrow.
  always_comb begin
    w_alu = '0;
    case (r_op_q)
      3'b010: w_alu = {1'b0, r_a} + {1'b0, w_bus};
      3'b011: w_alu = {1'b0, r_a} - {1'b0, w_bus};
      3'b100: w_alu = {1'b0, r_a & w_bus};
`ifdef PROC_XOR_EN
      3'b101: w_alu = {1'b0, r_a ^ w_bus};
`endif
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_q      <= '0;
      r_rx_q      <= '0;
      r_ry_q      <= '0;
      r_din_q     <= '0;
      r_a         <= '0;
      r_g         <= '0;
      r_carry_nxt <= 1'b0;
      r_carry     <= 1'b0;
      r_zero      <= 1'b0;
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      if (r_state == S_IDLE && p.w) begin
        r_op_q  <= p.op;
        r_rx_q  <= p.rx;
        r_ry_q  <= p.ry;
        r_din_q <= p.din;
      end
      case (r_state)
        S_LOAD, S_MOVE: r_regs[r_rx_q] <= w_bus;
        S_ALU_A:        r_a <= w_bus;
        S_ALU_G: begin
          r_g         <= w_alu[DATA_W-1:0];
          r_carry_nxt <= w_alu[DATA_W];
        end
        S_ALU_WB: begin
          r_regs[r_rx_q] <= r_g;
          r_carry        <= r_carry_nxt;
          r_zero         <= (r_g == '0);
        end
        default: ;
      endcase
    end
  end

  assign p.busy     = (r_state != S_IDLE);
  assign p.done     = (r_state == S_LOAD) || (r_state == S_MOVE) ||
                      (r_state == S_ALU_WB) || (r_state == S_ERR);
  assign p.err      = (r_state == S_ERR);
  assign p.carry    = r_carry;
  assign p.zero     = r_zero;
  assign p.bus      = w_bus;
  assign p.dbg_data = (32'(p.dbg_sel) < NREGS) ? r_regs[p.dbg_sel] : '0;
endmodule

// File: tb/tb_proc_fsm_param.sv
// Self-checking bench for proc_fsm_param: directed scenarios then random instructions
// compared against an arithmetic reference model of the register file and flags.
module tb_proc_fsm_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef PROC_XOR_EN
  localparam bit XOR_EN = 1'b1;
`else
  localparam bit XOR_EN = 1'b0;
`endif

  proc_fsm_param_if #(.DATA_W(8), .NREGS(4)) ifc ();
  proc_fsm_param #(.DATA_W(8), .NREGS(4)) dut (.clk(clk), .rst(rst), .p(ifc));

  int n_tests = 0;
  int n_fail  = 0;

  int unsigned m_r [4];
  bit          m_c;
  bit          m_z;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_c = 1'b0;
    m_z = 1'b0;
  endtask

  // Reference semantics: returns cycles from accept to done, and whether err is expected.
  task automatic model_exec(input int unsigned op, rx, ry, din, output int lat, output bit e);
    int unsigned a, b, res;
    a = m_r[rx]; b = m_r[ry]; e = 1'b0; lat = 3; res = 0;
    case (op)
      0: begin m_r[rx] = din; lat = 1; end
      1: begin m_r[rx] = b;   lat = 1; end
      2: begin res = a + b; m_c = (res > 255); res = res % 256; end
      3: begin m_c = (a < b); res = (a + 256 - b) % 256; end
      4: begin m_c = 1'b0; res = a & b; end
      5: begin
        if (XOR_EN) begin m_c = 1'b0; res = a ^ b; end
        else begin e = 1'b1; lat = 1; end
      end
      default: begin e = 1'b1; lat = 1; end
    endcase
    if (op >= 2 && !e) begin
      m_r[rx] = res;
      m_z = (res == 0);
    end
  endtask

  task automatic check_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      ifc.dbg_sel = 2'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(ifc.dbg_data), m_r[i]);
    end
    chk({tag, "_carry"}, 32'(ifc.carry), 32'(m_c));
    chk({tag, "_zero"},  32'(ifc.zero),  32'(m_z));
  endtask

  task automatic run(input logic [2:0] op, input logic [1:0] rx, input logic [1:0] ry,
                     input logic [7:0] din, input bit hold);
    int    lat, exp_lat;
    bit    exp_err, got_done, got_err;
    string tag;
    tag = $sformatf("op%0d_r%0d_r%0d", op, rx, ry);
    got_done = 1'b0; got_err = 1'b0; lat = 0;
    @(negedge clk);
    ifc.w = 1'b1; ifc.op = op; ifc.rx = rx; ifc.ry = ry; ifc.din = din;
    @(posedge clk);
    model_exec(op, rx, ry, din, exp_lat, exp_err);
    for (int c = 1; c <= 6 && !got_done; c++) begin
      @(negedge clk);
      ifc.w   = hold;
      ifc.op  = 3'($urandom);
      ifc.rx  = 2'($urandom);
      ifc.ry  = 2'($urandom);
      ifc.din = 8'($urandom);
      if (c == 1 && op == 3'b000) chk({tag, "_bus_din"}, 32'(ifc.bus), 32'(din));
      if (ifc.done) begin
        got_done = 1'b1; lat = c; got_err = ifc.err;
        if (exp_err) chk({tag, "_err_bus"}, 32'(ifc.bus), 0);
      end else begin
        chk({tag, "_busy"}, 32'(ifc.busy), 1);
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_err"}, 32'(got_err), 32'(exp_err));
    @(negedge clk);
    ifc.w = 1'b0;
    chk({tag, "_idle_busy"}, 32'(ifc.busy), 0);
    chk({tag, "_idle_done"}, 32'(ifc.done), 0);
    chk({tag, "_idle_bus"},  32'(ifc.bus),  0);
    check_state(tag);
  endtask

  task automatic read_reg(input int idx, output logic [7:0] v);
    ifc.dbg_sel = 2'(idx);
    #1;
    v = ifc.dbg_data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    ifc.w = 1'b0; ifc.op = '0; ifc.rx = '0; ifc.ry = '0; ifc.din = '0; ifc.dbg_sel = '0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy",  32'(ifc.busy),  0);
    chk("rst_done",  32'(ifc.done),  0);
    chk("rst_err",   32'(ifc.err),   0);
    chk("rst_bus",   32'(ifc.bus),   0);
    check_state("rst");
    rst = 1'b0;

    run(3'b000, 2'd2, 2'd0, 8'hA5, 1'b0);
    read_reg(2, v);
    chk("plan_load_r2", 32'(v), 32'h A5);

    run(3'b000, 2'd0, 2'd0, 8'hF0, 1'b0);
    run(3'b000, 2'd1, 2'd0, 8'h20, 1'b0);
    run(3'b010, 2'd0, 2'd1, 8'h00, 1'b0);
    read_reg(0, v);
    chk("plan_add_r0", 32'(v), 32'h10);
    chk("plan_add_carry", 32'(ifc.carry), 1);

    run(3'b000, 2'd3, 2'd0, 8'h05, 1'b0);
    run(3'b011, 2'd3, 2'd3, 8'h00, 1'b0);
    chk("plan_sub_zero", 32'(ifc.zero), 1);
    run(3'b000, 2'd0, 2'd0, 8'h01, 1'b0);
    run(3'b000, 2'd1, 2'd0, 8'h02, 1'b0);
    run(3'b011, 2'd0, 2'd1, 8'h00, 1'b0);

    run(3'b000, 2'd2, 2'd0, 8'h3C, 1'b0);
    run(3'b001, 2'd1, 2'd2, 8'h00, 1'b1);
    run(3'b010, 2'd1, 2'd1, 8'h00, 1'b1);

    run(3'b110, 2'd0, 2'd1, 8'h00, 1'b0);
    run(3'b111, 2'd2, 2'd3, 8'h00, 1'b0);
    run(3'b000, 2'd0, 2'd0, 8'hFF, 1'b0);
    run(3'b000, 2'd1, 2'd0, 8'h0F, 1'b0);
    run(3'b101, 2'd0, 2'd1, 8'h00, 1'b0);
    run(3'b100, 2'd0, 2'd1, 8'h00, 1'b0);

    // Reset during ALU_G of ADD R0,R1 must abort without a write or done pulse.
    @(negedge clk);
    ifc.w = 1'b1; ifc.op = 3'b010; ifc.rx = 2'd0; ifc.ry = 2'd1;
    @(posedge clk);
    @(negedge clk);
    ifc.w = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_done", 32'(ifc.done), 0);
    chk("midrst_busy", 32'(ifc.busy), 0);
    chk("midrst_bus",  32'(ifc.bus),  0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_state("midrst");
    run(3'b000, 2'd3, 2'd0, 8'h77, 1'b0);

    for (int k = 0; k < 60; k++) begin
      run(3'($urandom_range(0, 7)), 2'($urandom), 2'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
